// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word width, reset/NOP defaults and IF/ID record.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_INC        = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus4;
        logic              valid;
    } ifid_t;

    typedef enum logic [1:0] {
        IFID_FLUSH = 2'd0,
        IFID_LOAD  = 2'd1,
        IFID_HOLD  = 2'd2
    } ifid_op_e;

    // Branch targets are forced onto a word boundary before reaching the PC.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, loads pc_next when load_en is high.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [WORD_W-1:0] pc_next,
    output logic [WORD_W-1:0] pc
);

    logic [WORD_W-1:0] pc_d;
    logic [WORD_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: next-PC selection, taken-branch flush, hazard stalls.
// Define FETCH_DELAY_SLOT_EN to keep the instruction behind a taken branch (architectural delay slot).
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCSrc_D,
    input  logic [WORD_W-1:0] PCBranch_D,
    input  logic              Stall_F,
    input  logic              Stall_D,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] PC_F,
    output logic [WORD_W-1:0] Instr_D,
    output logic [WORD_W-1:0] PCPlus4_D,
    output logic              Valid_D
);

    logic [WORD_W-1:0] pc_plus4_f;
    logic [WORD_W-1:0] pc_next_f;
    logic              flush_d;
    ifid_op_e          ifid_op;
    ifid_t             ifid_d;
    ifid_t             ifid_q;

    // PC+4 wraps modulo 2^32; the carry out is simply dropped.
    assign pc_plus4_f = PC_F + PC_INC;
    assign pc_next_f  = PCSrc_D ? align_word(PCBranch_D) : pc_plus4_f;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (~Stall_F),
        .pc_next (pc_next_f),
        .pc      (PC_F)
    );

`ifdef FETCH_DELAY_SLOT_EN
    assign flush_d = 1'b0;
`else
    assign flush_d = PCSrc_D & ~Stall_D;
`endif

    always_comb begin
        ifid_op = IFID_HOLD;
        if (flush_d) begin
            ifid_op = IFID_FLUSH;
        end else if (!Stall_D) begin
            ifid_op = IFID_LOAD;
        end
    end

    always_comb begin
        ifid_d = ifid_q;
        case (ifid_op)
            IFID_FLUSH: begin
                ifid_d.instr    = NOP_INSTR;
                ifid_d.pc_plus4 = '0;
                ifid_d.valid    = 1'b0;
            end
            IFID_LOAD: begin
                ifid_d.instr    = imem_rdata;
                ifid_d.pc_plus4 = pc_plus4_f;
                ifid_d.valid    = 1'b1;
            end
            default: ifid_d = ifid_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign Instr_D   = ifid_q.instr;
    assign PCPlus4_D = ifid_q.pc_plus4;
    assign Valid_D   = ifid_q.valid;

    // Hazard unit must never stall decode while letting fetch advance.
`ifndef SYNTHESIS
    stall_contract: assert property (@(posedge clk) disable iff (!rst_n) !(Stall_D && !Stall_F));
`endif

endmodule
